// File: rtl/mul_add_seq_pkg.sv
// mul_add_seq_pkg
// Shared constants and types for the shift-and-add multiply-accumulate
// block. The width helpers are also used by div_restoring, which keeps the
// two blocks width-matched when one checks the other.
//   DEF_WA / DEF_WB : default multiplicand / multiplier widths
//   rem_width()     : remainder/addend width derived from the multiplier width
//   prod_width()    : product width derived from both operand widths
//   state_t         : FSM encoding shared by the sequential datapaths
package mul_add_seq_pkg;

  localparam int DEF_WA = 8;
  localparam int DEF_WB = 4;

  // The divider remainder is one bit wider than the divisor.
  function automatic int rem_width(input int wb);
    return wb + 1;
  endfunction

  // With WA > WB, q*b + r always fits in WA+WB bits.
  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  localparam int DEF_WR = rem_width(DEF_WB);
  localparam int DEF_WP = prod_width(DEF_WA, DEF_WB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_add_seq_if.sv
// mul_add_seq_if
// Start/busy/ready handshake and operand/result bus of mul_add_seq.
//   start : request, taken only when the block is idle or done
//   q     : multiplicand (WA bits)
//   b     : multiplier (WB bits)
//   r     : addend (WR bits)
//   p     : result (WP bits), valid while ready is high
//   busy  : iterating
//   ready : result valid, held until the next accepted start
//   count : iterations completed (WC bits)
// Modports: master drives the request side, slave is the mul_add_seq side.
interface mul_add_seq_if
  import mul_add_seq_pkg::*;
#(
  parameter int WA = DEF_WA,
  parameter int WB = DEF_WB
);

  localparam int WR = rem_width(WB);
  localparam int WP = prod_width(WA, WB);
  localparam int WC = $clog2(WB + 1);

  logic          start;
  logic [WA-1:0] q;
  logic [WB-1:0] b;
  logic [WR-1:0] r;
  logic [WP-1:0] p;
  logic          busy;
  logic          ready;
  logic [WC-1:0] count;

  modport master (
    output start, q, b, r,
    input  p, busy, ready, count
  );

  modport slave (
    input  start, q, b, r,
    output p, busy, ready, count
  );

endinterface

// File: rtl/mul_add_seq_step.sv
// mul_add_step
// One combinational shift-and-add iteration: sum = acc + (mbit ? mcand : 0).
//   acc   : running partial sum (WP bits)
//   mcand : multiplicand already shifted into position (WP bits)
//   mbit  : current multiplier bit
//   sum   : next partial sum (WP bits, unsigned, cannot overflow)
module mul_add_step #(
  parameter int WP = 12
) (
  input  logic [WP-1:0] acc,
  input  logic [WP-1:0] mcand,
  input  logic          mbit,
  output logic [WP-1:0] sum
);

  assign sum = acc + (mbit ? mcand : '0);

endmodule

// File: rtl/mul_add_seq.sv
// mul_add_seq
// Sequential multiply-accumulate p = q*b + r, one multiplier bit per clock.
// It rebuilds a dividend from the quotient, divisor and remainder of
// div_restoring, so it can check that divider or act as a small multiplier.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : mul_add_seq_if slave (start/q/b/r in, p/busy/ready/count out)
// The run always takes WB iterations, even for b = 0, so the latency from an
// accepted start to ready is fixed at WB cycles.
module mul_add_seq
  import mul_add_seq_pkg::*;
#(
  parameter int WA = DEF_WA,
  parameter int WB = DEF_WB
) (
  input  logic     clk,
  input  logic     clrn,
  mul_add_seq_if.slave bus
);

  localparam int WR = rem_width(WB);
  localparam int WP = prod_width(WA, WB);
  localparam int WC = $clog2(WB + 1);

  localparam logic [WC-1:0] LAST_ITER = WC'(WB - 1);

  state_t        state;
  logic [WP-1:0] acc;
  logic [WP-1:0] mcand;
  logic [WB-1:0] mplier;
  logic [WC-1:0] count;
  logic          busy;
  logic          ready;
  logic [WP-1:0] acc_next;

  mul_add_step #(.WP(WP)) u_step (
    .acc   (acc),
    .mcand (mcand),
    .mbit  (mplier[0]),
    .sum   (acc_next)
  );

  // Control and datapath in one block. Operands are captured only on an
  // accepted start (IDLE or DONE); in RUN a start is ignored. The edge that
  // completes iteration WB moves to DONE and swaps busy for ready in the same
  // cycle, so the two flags are never high together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            acc    <= WP'(bus.r);
            mcand  <= WP'(bus.q);
            mplier <= bus.b;
            count  <= '0;
            busy   <= 1'b1;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + WC'(1);
          if (count == LAST_ITER) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Partial sums show on p during RUN; only ready qualifies them.
  assign bus.p     = acc;
  assign bus.busy  = busy;
  assign bus.ready = ready;
  assign bus.count = count;

endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq
// Directed bench for mul_add_seq with default widths (WA=8, WB=4).
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
module tb_mul_add_seq;

  logic clk;
  logic clrn;
  int   n_checks;
  int   n_fail;

  mul_add_seq_if #(.WA(8), .WB(4)) bus ();

  mul_add_seq #(.WA(8), .WB(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents operands with start for exactly one edge (the start edge E0).
  task automatic applyStimulus(input logic [7:0] q, input logic [3:0] b,
                               input logic [4:0] r);
    bus.start = 1'b1;
    bus.q     = q;
    bus.b     = b;
    bus.r     = r;
    step();
    bus.start = 1'b0;
    bus.q     = '0;
    bus.b     = '0;
    bus.r     = '0;
  endtask

  // Full operation with the 4-cycle latency and final value checked.
  task automatic runOp(input string tag, input logic [7:0] q,
                       input logic [3:0] b, input logic [4:0] r,
                       input logic [11:0] exp_p);
    applyStimulus(q, b, r);
    checkOutput({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " ready after start"}, 32'(bus.ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("%s count E%0d", tag, i), 32'(bus.count), 32'(i));
      checkOutput($sformatf("%s ready E%0d", tag, i), 32'(bus.ready),
                  (i == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s busy E%0d", tag, i), 32'(bus.busy),
                  (i == 4) ? 32'd0 : 32'd1);
    end
    checkOutput({tag, " p"}, 32'(bus.p), 32'(exp_p));
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] d;
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.q     = '0;
    bus.b     = '0;
    bus.r     = '0;
    clrn      = 1'b0;
    step();
    step();
    clrn = 1'b1;
    step();

    $display("[TB] reset state");
    checkOutput("reset p", 32'(bus.p), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset ready", 32'(bus.ready), 32'd0);
    checkOutput("reset count", 32'(bus.count), 32'd0);

    $display("[TB] basic and max-operand runs");
    runOp("t1", 8'h0F, 4'd3, 5'd2, 12'h02F);
    runOp("t2", 8'hFF, 4'hF, 5'd30, 12'hF0F);

    // DONE holds while start stays low.
    step();
    step();
    step();
    checkOutput("hold ready", 32'(bus.ready), 32'd1);
    checkOutput("hold busy", 32'(bus.busy), 32'd0);
    checkOutput("hold p", 32'(bus.p), 32'hF0F);
    checkOutput("hold count", 32'(bus.count), 32'd4);

    $display("[TB] b=0 run then back-to-back start from DONE");
    runOp("t3", 8'd200, 4'd0, 5'd7, 12'd7);
    runOp("t4", 8'd1, 4'd1, 5'd0, 12'd1);

    $display("[TB] start during RUN is ignored");
    applyStimulus(8'd10, 4'd5, 5'd0);
    checkOutput("t5 count E0", 32'(bus.count), 32'd0);
    step();
    checkOutput("t5 count E1", 32'(bus.count), 32'd1);
    bus.start = 1'b1;
    bus.q     = 8'd255;
    bus.b     = 4'd15;
    bus.r     = 5'd31;
    step();
    bus.start = 1'b0;
    checkOutput("t5 count E2", 32'(bus.count), 32'd2);
    checkOutput("t5 busy E2", 32'(bus.busy), 32'd1);
    step();
    checkOutput("t5 count E3", 32'(bus.count), 32'd3);
    step();
    checkOutput("t5 count E4", 32'(bus.count), 32'd4);
    checkOutput("t5 ready", 32'(bus.ready), 32'd1);
    checkOutput("t5 p", 32'(bus.p), 32'd50);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(8'd100, 4'd7, 5'd3);
    step();
    step();
    checkOutput("t6 count before reset", 32'(bus.count), 32'd2);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("t6 p in reset", 32'(bus.p), 32'd0);
    checkOutput("t6 busy in reset", 32'(bus.busy), 32'd0);
    checkOutput("t6 ready in reset", 32'(bus.ready), 32'd0);
    checkOutput("t6 count in reset", 32'(bus.count), 32'd0);
    #3;
    clrn = 1'b1;
    step();
    step();
    step();
    checkOutput("t6 idle busy", 32'(bus.busy), 32'd0);
    checkOutput("t6 idle ready", 32'(bus.ready), 32'd0);
    checkOutput("t6 idle count", 32'(bus.count), 32'd0);
    runOp("t7", 8'd3, 4'd2, 5'd1, 12'd7);

    $display("[TB] divider round-trip vectors");
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom_range(255, 0));
      d = 4'($urandom_range(15, 1));
      applyStimulus(a / 8'(d), d, 5'(a % 8'(d)));
      for (int i = 0; i < 4; i++) step();
      checkOutput($sformatf("rt%0d ready", k), 32'(bus.ready), 32'd1);
      checkOutput($sformatf("rt%0d p a=%0d b=%0d", k, a, d), 32'(bus.p),
                  32'(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
